// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
package regfile_wb_scheduler_pkg;

    localparam int MAX_REG_ID = 16;
    localparam int REG_ID_W   = 4;
    localparam int VEC_BITS   = 256;
    localparam int TINY_CNT_W = 8;

    typedef logic [REG_ID_W-1:0]   RegisterID;
    typedef logic [VEC_BITS-1:0]   VectorValue;
    typedef logic [TINY_CNT_W-1:0] TinyCounter;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } sched_state_t;

    // The halted output drives this bit of machine_flags.
    localparam logic [31:0] MACHINE_FLAGS_MASK_HALT = 32'h0000_0001;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr, returns a one-hot grant
// and the pointer value to load when a grant is taken.
module regfile_wb_scheduler_rr_arbiter
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] nxt_ptr
);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt     = '0;
        nxt_ptr = ptr;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
                nxt_ptr  = PW'((idx + 1) % N);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates requesters onto the register-file write port,
// tracks pending writes per register and sequences halt.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int NUM_REGS = MAX_REG_ID,
    parameter int ID_W     = REG_ID_W,
    parameter int VEC_W    = VEC_BITS,
    parameter int CNT_W    = TINY_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       wb_valid,
    input  logic [NUM_REQ*ID_W-1:0]  wb_id,
    input  logic [NUM_REQ*VEC_W-1:0] wb_data,
    output logic [NUM_REQ-1:0]       wb_ready,
    output logic                     rf_we,
    output logic [ID_W-1:0]          rf_wid,
    output logic [VEC_W-1:0]         rf_wdata,
    input  logic                     iss_valid,
    input  logic [ID_W-1:0]          iss_id,
    output logic                     iss_ready,
    input  logic [ID_W-1:0]          rd_id,
    output logic                     rd_busy,
    input  logic                     halt_req,
    output logic                     halted,
    output logic                     err_underflow
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_t         state;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        nxt_ptr;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [CNT_W-1:0]     cnt [NUM_REGS];
    logic [NUM_REGS-1:0]  inc_vec;
    logic [NUM_REGS-1:0]  dec_vec;
    logic [ID_W-1:0]      win_id;
    logic [VEC_W-1:0]     win_data;
    logic                 iss_ok;
    logic                 rd_ok;
    logic                 commit_ok;
    logic                 iss_fire;
    logic                 all_idle;

    assign req = (rst_n && state != HALTED) ? wb_valid : '0;

    regfile_wb_scheduler_rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr_arbiter (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .nxt_ptr (nxt_ptr)
    );

    assign wb_ready  = gnt;
    assign iss_ok    = 32'(iss_id) < NUM_REGS;
    assign rd_ok     = 32'(rd_id) < NUM_REGS;
    assign commit_ok = rf_we && (32'(rf_wid) < NUM_REGS);
    assign iss_ready = rst_n && (state == RUN) && iss_ok && (cnt[iss_id] != '1);
    assign iss_fire  = iss_valid && iss_ready;
    assign rd_busy   = rd_ok && (cnt[rd_id] != '0);

    always_comb begin
        win_id   = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_id   = wb_id[i*ID_W +: ID_W];
                win_data = wb_data[i*VEC_W +: VEC_W];
            end
        end
    end

    always_comb begin
        inc_vec  = '0;
        dec_vec  = '0;
        all_idle = !rf_we && (wb_valid == '0);
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            inc_vec[r] = iss_fire && (32'(iss_id) == r);
            dec_vec[r] = commit_ok && (32'(rf_wid) == r);
            if (cnt[r] != '0) all_idle = 1'b0;
        end
    end

    // Simultaneous issue and commit on one register cancel; commits never wrap below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + CNT_W'(1);
                else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
            if (commit_ok && cnt[rf_wid] == '0) err_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            halted   <= 1'b0;
            rr_ptr   <= '0;
            rf_we    <= 1'b0;
            rf_wid   <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= |gnt;
            if (|gnt) begin
                rf_wid   <= win_id;
                rf_wdata <= win_data;
                rr_ptr   <= nxt_ptr;
            end
            case (state)
                RUN:    if (halt_req) state <= DRAIN;
                DRAIN:  if (all_idle) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                HALTED: halted <= 1'b1;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (iss_valid) assert (iss_ok);
            assert (rd_ok);
            if (|gnt) assert (32'(win_id) < NUM_REGS);
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus a random
// phase, all compared against a cycle-level behavioural model.
module tb_regfile_wb_scheduler;

    localparam int NUM_REQ  = 3;
    localparam int NUM_REGS = 16;
    localparam int ID_W     = 4;
    localparam int VEC_W    = 256;
    localparam int CNT_W    = 8;
    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_HALTED = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       wb_valid;
    logic [NUM_REQ*ID_W-1:0]  wb_id;
    logic [NUM_REQ*VEC_W-1:0] wb_data;
    logic [NUM_REQ-1:0]       wb_ready;
    logic                     rf_we;
    logic [ID_W-1:0]          rf_wid;
    logic [VEC_W-1:0]         rf_wdata;
    logic                     iss_valid;
    logic [ID_W-1:0]          iss_id;
    logic                     iss_ready;
    logic [ID_W-1:0]          rd_id;
    logic                     rd_busy;
    logic                     halt_req;
    logic                     halted;
    logic                     err_underflow;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(
        .NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .ID_W(ID_W), .VEC_W(VEC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_ready(wb_ready),
        .rf_we(rf_we), .rf_wid(rf_wid), .rf_wdata(rf_wdata),
        .iss_valid(iss_valid), .iss_id(iss_id), .iss_ready(iss_ready),
        .rd_id(rd_id), .rd_busy(rd_busy),
        .halt_req(halt_req), .halted(halted), .err_underflow(err_underflow)
    );

    int total = 0;
    int bad   = 0;

    // Requester intentions and reference model state
    bit               q_v [NUM_REQ];
    int               q_id[NUM_REQ];
    logic [VEC_W-1:0] q_d [NUM_REQ];
    int               m_cnt[NUM_REGS];
    int               m_ptr, m_state, m_wid, last_g;
    bit               m_we, m_err, m_halted;
    logic [VEC_W-1:0] m_wdata;

    task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int k = 0; k < VEC_W/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int m_grant();
        if (m_state == M_HALTED) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQ;
            if (q_v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit m_iss_ready();
        return (m_state == M_RUN) && (m_cnt[iss_id] < 255);
    endfunction

    task automatic apply_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            wb_valid[i]                = q_v[i];
            wb_id[i*ID_W +: ID_W]      = ID_W'(q_id[i]);
            wb_data[i*VEC_W +: VEC_W]  = q_d[i];
        end
    endtask

    task automatic m_reset();
        for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
        m_ptr = 0; m_state = M_RUN; m_wid = 0; m_we = 0; m_err = 0; m_halted = 0;
        m_wdata = '0; last_g = -1;
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic cycle();
        int g, inc_id, dec_id;
        bit fire, idle, hreq;
        logic [NUM_REQ-1:0] exp_rdy;
        apply_reqs();
        #1;
        g = m_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("wb_ready", VEC_W'(wb_ready), VEC_W'(exp_rdy));
        chk("iss_ready", VEC_W'(iss_ready), VEC_W'(m_iss_ready()));
        chk("rd_busy", VEC_W'(rd_busy), VEC_W'(m_cnt[rd_id] != 0));
        fire   = iss_valid && m_iss_ready();
        inc_id = fire ? int'(iss_id) : -1;
        dec_id = m_we ? m_wid : -1;
        hreq   = halt_req;
        idle   = !m_we;
        for (int r = 0; r < NUM_REGS; r++) if (m_cnt[r] != 0) idle = 0;
        for (int i = 0; i < NUM_REQ; i++) if (q_v[i]) idle = 0;
        @(posedge clk);
        if (dec_id >= 0 && m_cnt[dec_id] == 0) m_err = 1;
        if (inc_id != dec_id) begin
            if (inc_id >= 0) m_cnt[inc_id]++;
            if (dec_id >= 0 && m_cnt[dec_id] > 0) m_cnt[dec_id]--;
        end
        if (m_state == M_RUN && hreq) m_state = M_DRAIN;
        else if (m_state == M_DRAIN && idle) m_state = M_HALTED;
        m_halted = (m_state == M_HALTED);
        m_we = (g >= 0);
        if (g >= 0) begin
            m_wid   = q_id[g];
            m_wdata = q_d[g];
            m_ptr   = (g + 1) % NUM_REQ;
        end
        last_g = g;
        #1;
        chk("rf_we", VEC_W'(rf_we), VEC_W'(m_we));
        chk("rf_wid", VEC_W'(rf_wid), VEC_W'(m_wid));
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("halted", VEC_W'(halted), VEC_W'(m_halted));
        chk("err_underflow", VEC_W'(err_underflow), VEC_W'(m_err));
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin q_v[i] = 0; q_id[i] = 0; q_d[i] = '0; end
        iss_valid = 0; iss_id = '0; rd_id = '0; halt_req = 0;
        apply_reqs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        iss_id = 4'd3;
        m_reset();
        #2;
        chk("rst_rf_we", VEC_W'(rf_we), '0);
        chk("rst_rf_wid", VEC_W'(rf_wid), '0);
        chk("rst_rf_wdata", rf_wdata, '0);
        chk("rst_halted", VEC_W'(halted), '0);
        chk("rst_err", VEC_W'(err_underflow), '0);
        chk("rst_iss_ready", VEC_W'(iss_ready), '0);
        q_v[0] = 1; apply_reqs(); #1;
        chk("rst_wb_ready", VEC_W'(wb_ready), '0);
        q_v[0] = 0; apply_reqs();
        for (int r = 0; r < NUM_REGS; r++) begin
            rd_id = ID_W'(r); #1;
            chk("rst_rd_busy", VEC_W'(rd_busy), '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        do_reset();

        // Three issues to r3, then three commits from requester 0
        iss_valid = 1; iss_id = 4'd3; rd_id = 4'd3;
        repeat (3) cycle();
        iss_valid = 0;
        cycle();
        chk("busy_r3", VEC_W'(rd_busy), VEC_W'(1'b1));
        q_v[0] = 1; q_id[0] = 3;
        for (int k = 0; k < 3; k++) begin q_d[0] = rand_vec(); cycle(); end
        q_v[0] = 0;
        repeat (3) cycle();
        chk("busy_r3_clear", VEC_W'(rd_busy), '0);

        // Round-robin: realign pointer to 0, then all three requesters contend
        iss_valid = 1; iss_id = 4'd8; rd_id = 4'd8;
        repeat (7) cycle();
        iss_valid = 0;
        q_v[2] = 1; q_id[2] = 8; q_d[2] = rand_vec();
        cycle();
        for (int i = 0; i < NUM_REQ; i++) begin q_v[i] = 1; q_id[i] = 8; q_d[i] = rand_vec(); end
        repeat (6) cycle();
        for (int i = 0; i < NUM_REQ; i++) q_v[i] = 0;
        repeat (2) cycle();

        // Same-register issue and commit cancel; then underflow is sticky
        iss_valid = 1; iss_id = 4'd5; rd_id = 4'd5;
        cycle();
        iss_valid = 0; q_v[0] = 1; q_id[0] = 5; q_d[0] = rand_vec();
        cycle();
        q_v[0] = 0; iss_valid = 1;
        cycle();
        iss_valid = 0;
        cycle();
        chk("busy_r5_same", VEC_W'(rd_busy), VEC_W'(1'b1));
        q_v[0] = 1; cycle(); q_v[0] = 0; cycle();
        q_v[0] = 1; cycle(); q_v[0] = 0; cycle();
        chk("err_set", VEC_W'(err_underflow), VEC_W'(1'b1));
        repeat (3) cycle();
        chk("err_sticky", VEC_W'(err_underflow), VEC_W'(1'b1));

        // Counter saturation at all-ones blocks issue only to that register
        iss_valid = 1; iss_id = 4'd2;
        repeat (255) cycle();
        #2;
        chk("iss_full_r2", VEC_W'(iss_ready), '0);
        iss_id = 4'd4; #1;
        chk("iss_free_r4", VEC_W'(iss_ready), VEC_W'(1'b1));
        iss_id = 4'd2;
        cycle();
        iss_valid = 0;

        // Random traffic; requesters keep id/data stable until granted
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!q_v[i] || last_g == i) begin
                    q_v[i]  = ($urandom_range(0, 9) < 4);
                    q_id[i] = $urandom_range(0, NUM_REGS-1);
                    q_d[i]  = rand_vec();
                end else if ($urandom_range(0, 19) == 0) begin
                    q_v[i] = 0;
                end
            end
            iss_valid = ($urandom_range(0, 9) < 7);
            iss_id    = ID_W'($urandom_range(0, NUM_REGS-1));
            rd_id     = ID_W'($urandom_range(0, NUM_REGS-1));
            cycle();
        end
        clear_inputs();
        cycle();

        // Drain every pending write
        for (int r = 0; r < NUM_REGS; r++) begin
            n = m_cnt[r];
            if (n > 0) begin
                q_v[0] = 1; q_id[0] = r; q_d[0] = rand_vec();
                repeat (n) cycle();
                q_v[0] = 0;
            end
        end
        repeat (2) cycle();
        for (int r = 0; r < NUM_REGS; r++) begin rd_id = ID_W'(r); cycle(); end

        // Halt with writes pending on r1 and r7
        iss_valid = 1; iss_id = 4'd1; cycle();
        iss_id = 4'd7; cycle();
        iss_valid = 0; halt_req = 1; cycle();
        halt_req = 0; iss_valid = 1; iss_id = 4'd4;
        cycle();
        chk("drain_iss_blocked", VEC_W'(iss_ready), '0);
        iss_valid = 0;
        q_v[0] = 1; q_id[0] = 1; q_d[0] = rand_vec();
        q_v[1] = 1; q_id[1] = 7; q_d[1] = rand_vec();
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (last_g >= 0) q_v[last_g] = 0;
        end
        chk("halted_final", VEC_W'(halted), VEC_W'(1'b1));
        for (int i = 0; i < NUM_REQ; i++) begin q_v[i] = 1; q_id[i] = 6; end
        iss_valid = 1;
        repeat (2) cycle();
        clear_inputs();

        // Reset mid-drain with a write registered but not committed
        do_reset();
        iss_valid = 1; iss_id = 4'd9; cycle();
        iss_valid = 0; halt_req = 1; cycle();
        halt_req = 0; q_v[0] = 1; q_id[0] = 9; q_d[0] = rand_vec();
        cycle();
        chk("inflight_we", VEC_W'(rf_we), VEC_W'(1'b1));
        do_reset();
        iss_valid = 1; iss_id = 4'd3; rd_id = 4'd3;
        cycle();
        iss_valid = 0;
        cycle();
        chk("post_reset_issue", VEC_W'(rd_busy), VEC_W'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sits between the execution units and the vector register file.
- Round-robin arbitrates NUM_REQ write-back requesters onto the single register-file write port.
- Keeps a per-register pending-write scoreboard: issue increments, commit decrements, readers see busy.
- Sequences halt: blocks new issue, drains all pending writes, then asserts halted.

Parameters:
- NUM_REQ, 3, number of write-back requesters (ALU, load/store, misc).
- NUM_REGS, 16, number of vector registers (MAX_REG_ID).
- ID_W, 4, register id width, equal to clog2(NUM_REGS).
- VEC_W, 256, VectorValue width in bits.
- CNT_W, 8, pending counter width (TinyCounter).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  NUM_REQ  per-requester write-back request.
- wb_id  in  NUM_REQ*ID_W  target register per requester (requester i in slice i).
- wb_data  in  NUM_REQ*VEC_W  write data per requester.
- wb_ready  out  NUM_REQ  one-hot grant.
- rf_we  out  1  register-file write enable.
- rf_wid  out  ID_W  register-file write id.
- rf_wdata  out  VEC_W  register-file write data.
- iss_valid  in  1  issue marks a destination register invalid.
- iss_id  in  ID_W  destination register of the issue.
- iss_ready  out  1  issue accepted this cycle.
- rd_id  in  ID_W  register being queried by decode.
- rd_busy  out  1  the queried register has pending writes.
- halt_req  in  1  request halt (level, sampled in RUN).
- halted  out  1  machine halted.
- err_underflow  out  1  sticky flag: commit to a register with pending count 0.

Behaviour:
- Async reset (rst_n low): every counter is 0, rr_ptr=0, state=RUN. All outputs are 0: rf_we, rf_wid, rf_wdata, wb_ready, halted, err_underflow. iss_ready is 0 during reset.
- A handshake completes when wb_valid[i] and wb_ready[i] are both high. wb_ready is combinational from wb_valid and rr_ptr. At most one bit is set, and only if the matching wb_valid is set.
- Arbitration: pick the first valid requester scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ. After a grant to requester g, rr_ptr becomes (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Requesters hold valid, id and data stable until granted. Dropping valid without a grant is legal, and no write occurs.
- Commit latency: a grant in cycle N produces rf_we=1 in cycle N+1, with rf_wid/rf_wdata registered from the winner. rf_we=0 otherwise; rf_wid/rf_wdata hold their last value.
- Counter decrement happens on the clock edge that ends the rf_we cycle (the commit edge). rd_busy clears in the cycle after rf_we, when the data is already readable.
- Issue: iss_ready = (state==RUN) && (cnt[iss_id] != all-ones). On iss_valid && iss_ready, cnt[iss_id] increments.
- Same register, same cycle, increment and commit: the count is unchanged. Different registers: both update.
- Commit when cnt==0: the counter stays 0 (no wrap) and err_underflow is set. It stays set until reset.
- rd_busy = (cnt[rd_id] != 0), combinational.
- Out-of-range ids (at or above NUM_REGS) on iss_id or rd_id: the issue is ignored, iss_ready=0, rd_busy=0. An out-of-range wb_id commit is dropped: rf_we is still asserted but the counter is unchanged. Simulation asserts on all three cases.
- FSM:
  - RUN: halt_req moves to DRAIN.
  - DRAIN: iss_ready=0 and arbitration continues. When all counters are 0, no wb_valid is high and rf_we=0, move to HALTED.
  - HALTED: halted=1, iss_ready=0, wb_ready=0. Exit only by reset.
- Reset mid-operation clears all state. A write already registered but not yet committed is discarded.

Decomposition:
- Shared package holds:
  - RegisterID, VectorValue and TinyCounter typedefs;
  - the MAX_REG_ID constant;
  - the sched_state_t enum {RUN, DRAIN, HALTED};
  - MACHINE_FLAGS_MASK_HALT (the halted output feeds the machine_flags halt bit).
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin, valid vector in, one-hot grant plus pointer update out). It is reusable for other shared ports.

Test Plan:
- Reset, then iss id=3 for 3 cycles → cnt[3]=3, rd_id=3 gives rd_busy=1. Requester 0 writes id=3 three times → three rf_we pulses with rf_wid=3. rd_busy drops one cycle after the third rf_we.
- All 3 requesters valid continuously, rr_ptr=0 → grants 0,1,2,0,1,2, one per cycle, with rf_wdata matching each requester's data one cycle later.
- Same-cycle issue id=5 and commit id=5 with cnt[5]=1 → cnt[5] stays 1 and rd_busy stays 1. Commit id=5 with cnt[5]=0 → err_underflow=1 and stays high.
- Issue id=2 255 times → cnt=255, iss_ready=0 on the next issue of id=2, while iss_ready=1 for id=4.
- Pending writes on id=1 and id=7, assert halt_req → iss_ready=0 immediately. halted=1 the cycle after both counters reach 0 and rf_we falls.
- rst_n low mid-DRAIN with a grant in flight → rf_we=0, halted=0, all counters 0, state=RUN. The next issue is accepted.
